// File: rtl/perf_sel_pkg.sv
// Shared constants and types for the windowed perf selector.
// The entry struct is sized for the default 8-bit record datapath.
package perf_sel_pkg;
  localparam int MODE_MIN  = 0;
  localparam int MODE_MAX  = 1;
  localparam int ENT_DSIZE = 8;

  typedef struct packed {
    logic [ENT_DSIZE-1:0]   account;
    logic [2*ENT_DSIZE-1:0] perf;
  } win_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/perf_window_selector_argsel.sv
// Balanced combinational arg-min/arg-max tree over N {account, perf} entries.
// Index N-1 is the newest entry; on equal perf the newer entry wins.
module perf_argsel_tree #(
  parameter int N        = 5,
  parameter int DSIZE    = 8,
  parameter int MODE_MAX = 0
) (
  input  logic [N-1:0][DSIZE-1:0]   acc,
  input  logic [N-1:0][2*DSIZE-1:0] perf,
  output logic [DSIZE-1:0]          sel_acc,
  output logic [2*DSIZE-1:0]        sel_perf
);
  import perf_sel_pkg::*;

  generate
    if (N == 1) begin : g_leaf
      assign sel_acc  = acc[0];
      assign sel_perf = perf[0];
    end else begin : g_node
      localparam int NL = N / 2;
      localparam int NH = N - NL;

      logic [DSIZE-1:0]   lo_acc, hi_acc;
      logic [2*DSIZE-1:0] lo_perf, hi_perf;
      logic               lo_better;

      perf_argsel_tree #(.N(NL), .DSIZE(DSIZE), .MODE_MAX(MODE_MAX)) u_lo (
        .acc      (acc[NL-1:0]),
        .perf     (perf[NL-1:0]),
        .sel_acc  (lo_acc),
        .sel_perf (lo_perf)
      );

      perf_argsel_tree #(.N(NH), .DSIZE(DSIZE), .MODE_MAX(MODE_MAX)) u_hi (
        .acc      (acc[N-1:NL]),
        .perf     (perf[N-1:NL]),
        .sel_acc  (hi_acc),
        .sel_perf (hi_perf)
      );

      // The older half only wins on a strict improvement, so ties resolve to the newer half.
      assign lo_better = (MODE_MAX == perf_sel_pkg::MODE_MAX) ? (lo_perf > hi_perf)
                                                              : (lo_perf < hi_perf);
      assign sel_acc  = lo_better ? lo_acc  : hi_acc;
      assign sel_perf = lo_better ? lo_perf : hi_perf;
    end
  endgenerate
endmodule

// File: rtl/perf_window_selector.sv
// Sliding-window account selector: keeps the last WIN (account, A*T) records and
// emits the min (or max) perf account once per accepted record after the window fills.
module perf_window_selector #(
  parameter int DSIZE    = 8,
  parameter int WIN      = 5,
  parameter int MODE_MAX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DSIZE-1:0]   in_account,
  input  logic [DSIZE-1:0]   in_A,
  input  logic [DSIZE-1:0]   in_T,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DSIZE-1:0]   out_account,
  output logic [2*DSIZE-1:0] out_perf
);
  import perf_sel_pkg::*;

  localparam int             PW       = 2 * DSIZE;
  localparam int             CW       = clog2(WIN + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIN);

  logic [WIN-1:0][DSIZE-1:0] win_acc;
  logic [WIN-1:0][PW-1:0]    win_perf;
  logic [CW-1:0]             count, count_nxt;
  logic                      pend;
  logic                      accept, load, fill;
  logic [PW-1:0]             in_perf;
  logic [DSIZE-1:0]          sel_acc;
  logic [PW-1:0]             sel_perf;

  assign in_perf  = PW'(in_A) * PW'(in_T);
  assign in_ready = !rst && (!pend || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = pend && (!out_valid || out_ready);

  // A flush coinciding with an accept restarts the window on the new record.
  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = accept ? CW'(1) : '0;
    else if (accept && count != CNT_FULL)
      count_nxt = count + CW'(1);
  end

  assign fill = accept && (count_nxt == CNT_FULL);

  perf_argsel_tree #(.N(WIN), .DSIZE(DSIZE), .MODE_MAX(MODE_MAX)) u_sel (
    .acc      (win_acc),
    .perf     (win_perf),
    .sel_acc  (sel_acc),
    .sel_perf (sel_perf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      win_acc     <= '0;
      win_perf    <= '0;
      count       <= '0;
      pend        <= 1'b0;
      out_valid   <= 1'b0;
      out_account <= '0;
      out_perf    <= '0;
    end else begin
      if (accept) begin
        win_acc  <= {in_account, win_acc[WIN-1:1]};
        win_perf <= {in_perf, win_perf[WIN-1:1]};
      end
      count <= count_nxt;

      if (fill)
        pend <= 1'b1;
      else if (load || flush)
        pend <= 1'b0;

      // Load samples the window as it stood before this edge's accept.
      if (load) begin
        out_valid   <= 1'b1;
        out_account <= sel_acc;
        out_perf    <= sel_perf;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
        out_account <= '0;
        out_perf    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_perf_window_selector.sv
// Directed table-driven bench for perf_window_selector; a min-mode and a max-mode
// instance share one input stream and are checked against hand-computed results.
module tb_perf_window_selector;
  logic        clk, rst, in_valid, flush, out_ready;
  logic [7:0]  in_account, in_A, in_T;
  logic        rdy_n, ov_n, rdy_x, ov_x;
  logic [7:0]  acc_n, acc_x;
  logic [15:0] perf_n, perf_x;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, v;
    logic [7:0]  acc, a, t;
    logic        fl, ordy;
    logic        erdy, eov;
    logic [7:0]  eacc;
    logic [15:0] eperf;
    logic [7:0]  emacc;
    logic [15:0] emperf;
  } vec_t;

  vec_t tbl[$];

  perf_window_selector #(.DSIZE(8), .WIN(5), .MODE_MAX(0)) u_min (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_n),
    .in_account(in_account), .in_A(in_A), .in_T(in_T), .flush(flush),
    .out_valid(ov_n), .out_ready(out_ready), .out_account(acc_n), .out_perf(perf_n)
  );

  perf_window_selector #(.DSIZE(8), .WIN(5), .MODE_MAX(1)) u_max (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_x),
    .in_account(in_account), .in_A(in_A), .in_T(in_T), .flush(flush),
    .out_valid(ov_x), .out_ready(out_ready), .out_account(acc_x), .out_perf(perf_x)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic v, input int acc, input int a,
                              input int t, input logic fl, input logic ordy, input logic erdy,
                              input logic eov, input int eacc, input int eperf,
                              input int emacc, input int emperf);
    vec_t c;
    c.rst = r; c.v = v; c.acc = 8'(acc); c.a = 8'(a); c.t = 8'(t);
    c.fl = fl; c.ordy = ordy; c.erdy = erdy; c.eov = eov;
    c.eacc = 8'(eacc); c.eperf = 16'(eperf); c.emacc = 8'(emacc); c.emperf = 16'(emperf);
    return c;
  endfunction

  // Record with out_ready=1 and no output expected after the edge.
  function automatic vec_t rec(input int acc, input int a, input int t, input logic fl);
    return mk(0, 1, acc, a, t, fl, 1, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t idle(input logic fl);
    return mk(0, 0, 0, 0, 0, fl, 1, 1, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t res(input int eacc, input int eperf, input int emacc, input int emperf);
    return mk(0, 0, 0, 0, 0, 0, 1, 1, 1, eacc, eperf, emacc, emperf);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle: in_ready checked before the edge, registered outputs after it.
  task automatic step(input vec_t c, input string nm);
    rst = c.rst; in_valid = c.v; in_account = c.acc; in_A = c.a; in_T = c.t;
    flush = c.fl; out_ready = c.ordy;
    @(negedge clk);
    chk({nm, " min in_ready"}, 32'(rdy_n), 32'(c.erdy));
    chk({nm, " max in_ready"}, 32'(rdy_x), 32'(c.erdy));
    @(posedge clk);
    #1;
    chk({nm, " min out_valid"}, 32'(ov_n), 32'(c.eov));
    chk({nm, " min out_account"}, 32'(acc_n), 32'(c.eacc));
    chk({nm, " min out_perf"}, 32'(perf_n), 32'(c.eperf));
    chk({nm, " max out_valid"}, 32'(ov_x), 32'(c.eov));
    chk({nm, " max out_account"}, 32'(acc_x), 32'(c.emacc));
    chk({nm, " max out_perf"}, 32'(perf_x), 32'(c.emperf));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_account = '0; in_A = '0; in_T = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state, in_ready low during reset.
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rst0");
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rst1");

    // Basic fill, newest-wins tie (acc 2 and 4 both perf 6), then one more record.
    tbl.push_back(rec(1, 3, 4, 0));
    tbl.push_back(rec(2, 2, 3, 0));
    tbl.push_back(rec(3, 4, 5, 0));
    tbl.push_back(rec(4, 3, 2, 0));
    tbl.push_back(rec(5, 5, 6, 0));
    tbl.push_back(res(4, 6, 5, 30));
    tbl.push_back(rec(6, 1, 1, 0));
    tbl.push_back(res(6, 1, 5, 30));
    tbl.push_back(idle(0));
    // Four records then idle: no output until the fifth.
    tbl.push_back(idle(1));
    tbl.push_back(rec(10, 2, 2, 0));
    tbl.push_back(rec(11, 1, 5, 0));
    tbl.push_back(rec(12, 3, 3, 0));
    tbl.push_back(rec(13, 2, 1, 0));
    tbl.push_back(idle(0));
    tbl.push_back(idle(0));
    tbl.push_back(rec(14, 1, 3, 0));
    tbl.push_back(res(13, 2, 12, 9));
    tbl.push_back(idle(0));
    // Partial fill, flush, refill with 9,8,7,8,9 (max tie resolves to newest).
    tbl.push_back(idle(1));
    tbl.push_back(rec(20, 1, 1, 0));
    tbl.push_back(rec(21, 1, 2, 0));
    tbl.push_back(rec(22, 1, 3, 0));
    tbl.push_back(idle(1));
    tbl.push_back(rec(30, 3, 3, 0));
    tbl.push_back(rec(31, 2, 4, 0));
    tbl.push_back(rec(32, 7, 1, 0));
    tbl.push_back(rec(33, 4, 2, 0));
    tbl.push_back(rec(34, 9, 1, 0));
    tbl.push_back(res(32, 7, 34, 9));
    tbl.push_back(idle(0));
    // Flush together with an accept: that record counts as the first entry.
    tbl.push_back(rec(40, 1, 1, 1));
    tbl.push_back(rec(41, 2, 2, 0));
    tbl.push_back(rec(42, 3, 1, 0));
    tbl.push_back(rec(43, 5, 1, 0));
    tbl.push_back(rec(44, 2, 3, 0));
    tbl.push_back(res(40, 1, 44, 6));
    tbl.push_back(idle(0));
    // Full-width product 255*255.
    tbl.push_back(idle(1));
    tbl.push_back(rec(50, 1, 1, 0));
    tbl.push_back(rec(51, 255, 255, 0));
    tbl.push_back(rec(52, 2, 2, 0));
    tbl.push_back(rec(53, 3, 3, 0));
    tbl.push_back(rec(54, 1, 2, 0));
    tbl.push_back(res(50, 1, 51, 65025));
    tbl.push_back(idle(0));

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Backpressure: one extra record absorbed, then in_ready drops and outputs hold.
    step(mk(0, 1, 60, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0), "bp_a");
    step(mk(0, 1, 61, 0, 7, 0, 0, 1, 1, 60, 1, 51, 65025), "bp_b");
    step(mk(0, 1, 62, 1, 1, 0, 0, 0, 1, 60, 1, 51, 65025), "bp_c");
    step(mk(0, 1, 62, 1, 1, 0, 0, 0, 1, 60, 1, 51, 65025), "bp_d");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 61, 0, 53, 9), "bp_e");
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "bp_f");

    // Reset while out_valid and pend are both set.
    step(mk(0, 1, 70, 2, 2, 0, 0, 1, 0, 0, 0, 0, 0), "rs_g");
    step(mk(0, 1, 71, 1, 1, 0, 0, 1, 1, 61, 0, 53, 9), "rs_h");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rs_i");
    step(idle(0), "rs_j");
    step(rec(80, 1, 5, 0), "rs_80");
    step(rec(81, 1, 3, 0), "rs_81");
    step(rec(82, 1, 8, 0), "rs_82");
    step(rec(83, 1, 3, 0), "rs_83");
    step(idle(0), "rs_k");
    step(rec(84, 1, 9, 0), "rs_84");
    step(res(83, 3, 84, 9), "rs_out");
    step(idle(0), "rs_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
